rv32i_regfile_mp: RTL and testbench



---
 rtl/rv32i_regfile_pkg.sv | 15 +
 rtl/rv32i_scoreboard.sv | 52 +++++
 rtl/rv32i_regfile_mp.sv | 91 +++++++++
 tb/tb_rv32i_regfile_mp.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_regfile_pkg.sv
// rtl/rv32i_regfile_pkg.sv - shared defaults, address-width helper and slice types for the multi-port register file
package rv32i_regfile_pkg;

  localparam int DEFAULT_NUM_OF_SETS    = 32;
  localparam int DEFAULT_DATA_BUS_WIDTH = 32;

  // Keeps a 1-bit address when depth collapses to 1, so slices never go zero-width.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic [addr_width(DEFAULT_NUM_OF_SETS)-1:0] reg_addr_t;
  typedef logic [DEFAULT_DATA_BUS_WIDTH-1:0]          reg_data_t;

endpackage

// File: rtl/rv32i_scoreboard.sv
// rtl/rv32i_scoreboard.sv - pending-destination tracker with reserve, release and flush
module rv32i_scoreboard
  import rv32i_regfile_pkg::*;
#(
  parameter int NUM_OF_SETS  = DEFAULT_NUM_OF_SETS,
  parameter int NUM_RD_PORTS = 3,
  parameter int NUM_WR_PORTS = 2,
  parameter int ZERO_REG_EN  = 1,
  localparam int AW          = addr_width(NUM_OF_SETS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WR_PORTS-1:0]      wr_enable,
  input  logic [NUM_WR_PORTS*AW-1:0]   wr_addr,
  input  logic [NUM_RD_PORTS*AW-1:0]   rd_addr,
  input  logic [NUM_RD_PORTS-1:0]      rd_fwd,
  input  logic                         rsv_en,
  input  logic [AW-1:0]                rsv_addr,
  input  logic                         flush,
  output logic [NUM_RD_PORTS-1:0]      rd_busy,
  output logic                         any_busy
);

  logic [NUM_OF_SETS-1:0] pending;
  logic [NUM_OF_SETS-1:0] pending_nxt;

  // Release first, then reserve, so a new producer in the same cycle keeps the bit set.
  always_comb begin
    pending_nxt = pending;
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      if (wr_enable[w]) pending_nxt[wr_addr[w*AW +: AW]] = 1'b0;
    end
    if (rsv_en) pending_nxt[rsv_addr] = 1'b1;
    if (flush) pending_nxt = '0;
    if (ZERO_REG_EN != 0) pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= pending_nxt;
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NUM_RD_PORTS; i++) begin
      rd_busy[i] = pending[rd_addr[i*AW +: AW]] & ~rd_fwd[i];
    end
  end

  assign any_busy = |pending;

endmodule

// File: rtl/rv32i_regfile_mp.sv
// rtl/rv32i_regfile_mp.sv - multi-port register file with priority writes, bypass and hazard scoreboard
module rv32i_regfile_mp
  import rv32i_regfile_pkg::*;
#(
  parameter int NUM_OF_SETS    = DEFAULT_NUM_OF_SETS,
  parameter int DATA_BUS_WIDTH = DEFAULT_DATA_BUS_WIDTH,
  parameter int NUM_RD_PORTS   = 3,
  parameter int NUM_WR_PORTS   = 2,
  parameter int ZERO_REG_EN    = 1,
  parameter int BYPASS_EN      = 1,
  localparam int AW            = addr_width(NUM_OF_SETS)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_WR_PORTS-1:0]                wr_enable,
  input  logic [NUM_WR_PORTS*AW-1:0]             wr_addr,
  input  logic [NUM_WR_PORTS*DATA_BUS_WIDTH-1:0] wr_data,
  input  logic [NUM_RD_PORTS*AW-1:0]             rd_addr,
  output logic [NUM_RD_PORTS*DATA_BUS_WIDTH-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]                rd_busy,
  input  logic                                   rsv_en,
  input  logic [AW-1:0]                          rsv_addr,
  input  logic                                   flush,
  output logic                                   any_busy
);

  localparam int DW = DATA_BUS_WIDTH;

  logic [DW-1:0]           regs [NUM_OF_SETS];
  logic [NUM_WR_PORTS-1:0] wr_ok;
  logic [NUM_RD_PORTS-1:0] rd_fwd;

  // A write to the hard-wired zero register neither stores nor forwards.
  always_comb begin
    wr_ok = '0;
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      wr_ok[w] = wr_enable[w] &&
                 !((ZERO_REG_EN != 0) && (wr_addr[w*AW +: AW] == '0));
    end
  end

  // Ascending port order: the last non-blocking update wins, giving the highest index priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NUM_OF_SETS; s++) regs[s] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
        if (wr_ok[w]) regs[wr_addr[w*AW +: AW]] <= wr_data[w*DW +: DW];
      end
    end
  end

  always_comb begin
    logic [AW-1:0] a;
    logic [DW-1:0] word;
    rd_data = '0;
    rd_fwd  = '0;
    for (int i = 0; i < NUM_RD_PORTS; i++) begin
      a    = rd_addr[i*AW +: AW];
      word = regs[a];
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
        if ((BYPASS_EN != 0) && wr_ok[w] && (wr_addr[w*AW +: AW] == a)) begin
          word      = wr_data[w*DW +: DW];
          rd_fwd[i] = 1'b1;
        end
      end
      if ((ZERO_REG_EN != 0) && (a == '0)) word = '0;
      rd_data[i*DW +: DW] = word;
    end
  end

  rv32i_scoreboard #(
    .NUM_OF_SETS  (NUM_OF_SETS),
    .NUM_RD_PORTS (NUM_RD_PORTS),
    .NUM_WR_PORTS (NUM_WR_PORTS),
    .ZERO_REG_EN  (ZERO_REG_EN)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wr_enable (wr_enable),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
    .rd_fwd    (rd_fwd),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .flush     (flush),
    .rd_busy   (rd_busy),
    .any_busy  (any_busy)
  );

endmodule

// File: tb/tb_rv32i_regfile_mp.sv
// tb/tb_rv32i_regfile_mp.sv - randomized and directed check of two register file configurations against a reference model
module tb_rv32i_regfile_mp;

  localparam int N  = 32;
  localparam int DW = 32;
  localparam int NR = 3;
  localparam int NW = 2;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NW-1:0]    wr_enable;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NR*AW-1:0] rd_addr;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             flush;

  logic [NR*DW-1:0] rd_data_a, rd_data_b;
  logic [NR-1:0]    rd_busy_a, rd_busy_b;
  logic             any_busy_a, any_busy_b;

  rv32i_regfile_mp dut_a (
    .clk(clk), .rst(rst), .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .flush(flush), .any_busy(any_busy_a)
  );

  rv32i_regfile_mp #(.ZERO_REG_EN(0), .BYPASS_EN(0)) dut_b (
    .clk(clk), .rst(rst), .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .flush(flush), .any_busy(any_busy_b)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_regs [2][N];
  bit            m_pend [2][N];
  bit            cfg_zero [2] = '{1'b1, 1'b0};
  bit            cfg_byp  [2] = '{1'b1, 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int wa(int w);
    return int'(wr_addr[w*AW +: AW]);
  endfunction

  function automatic int ra(int i);
    return int'(rd_addr[i*AW +: AW]);
  endfunction

  // Index of the highest-numbered write port that forwards to address a, or -1.
  function automatic int fwd_port(int c, int a);
    if (!cfg_byp[c]) return -1;
    if (cfg_zero[c] && a == 0) return -1;
    for (int w = NW - 1; w >= 0; w--) begin
      if (wr_enable[w] && wa(w) == a) return w;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_data(int c, int a);
    int p;
    if (cfg_zero[c] && a == 0) return 32'h0;
    p = fwd_port(c, a);
    if (p >= 0) return wr_data[p*DW +: DW];
    return m_regs[c][a];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < N; r++) begin
        m_regs[c][r] = '0;
        m_pend[c][r] = 1'b0;
      end
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      for (int w = 0; w < NW; w++) begin
        if (wr_enable[w] && !(cfg_zero[c] && wa(w) == 0)) m_regs[c][wa(w)] = wr_data[w*DW +: DW];
      end
      if (flush) begin
        for (int r = 0; r < N; r++) m_pend[c][r] = 1'b0;
      end else begin
        for (int w = 0; w < NW; w++) if (wr_enable[w]) m_pend[c][wa(w)] = 1'b0;
        if (rsv_en) m_pend[c][rsv_addr] = 1'b1;
      end
      if (cfg_zero[c]) m_pend[c][0] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    for (int c = 0; c < 2; c++) begin
      bit any = 1'b0;
      for (int r = 0; r < N; r++) any |= m_pend[c][r];
      check($sformatf("cfg%0d_any_busy", c), (c == 0) ? any_busy_a : any_busy_b, any);
      for (int i = 0; i < NR; i++) begin
        int a = ra(i);
        logic [31:0] got_d = (c == 0) ? rd_data_a[i*DW +: DW] : rd_data_b[i*DW +: DW];
        logic got_b = (c == 0) ? rd_busy_a[i] : rd_busy_b[i];
        bit exp_b = m_pend[c][a] && (fwd_port(c, a) < 0);
        check($sformatf("cfg%0d_rd%0d_x%0d_data", c, i, a), got_d, exp_data(c, a));
        check($sformatf("cfg%0d_rd%0d_x%0d_busy", c, i, a), got_b, exp_b);
      end
    end
  endtask

  task automatic check_point();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    wr_enable = '0;
    wr_addr   = '0;
    wr_data   = '0;
    rsv_en    = 1'b0;
    rsv_addr  = '0;
    flush     = 1'b0;
  endtask

  task automatic set_wr(input int p, input int a, input logic [31:0] d);
    wr_enable[p]       = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2);
    rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  initial begin
    set_idle();
    set_rd(1, 5, 31);
    model_reset();
    #2;
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // write x4, then reset while a second write to x4 is presented
    set_wr(0, 4, 32'h0000_0055);
    check_point(); advance();
    set_idle(); set_wr(0, 4, 32'h0000_0066);
    rst = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_idle(); set_rd(4, 4, 4);
    check_point();
    check("rst_midwrite_x4", rd_data_a[DW-1:0], 32'h0);
    advance();

    // same-address write collision
    set_wr(0, 5, 32'hAAAA_0000); set_wr(1, 5, 32'h1234_5678); set_rd(5, 1, 2);
    check_point(); advance();
    set_idle();
    check_point();
    check("collide_x5_a", rd_data_a[DW-1:0], 32'h1234_5678);
    check("collide_x5_b", rd_data_b[DW-1:0], 32'h1234_5678);
    advance();

    // same-cycle bypass
    set_wr(0, 7, 32'hDEAD_BEEF); set_rd(1, 7, 2);
    check_point();
    check("bypass_x7_a", rd_data_a[DW +: DW], 32'hDEAD_BEEF);
    check("nobypass_x7_b", rd_data_b[DW +: DW], 32'h0);
    advance();

    // zero register
    set_idle(); set_wr(0, 0, 32'hFFFF_FFFF); rsv_en = 1'b1; rsv_addr = '0; set_rd(0, 0, 0);
    check_point(); advance();
    set_idle();
    check_point();
    check("x0_data_a", rd_data_a[DW-1:0], 32'h0);
    check("x0_busy_a", rd_busy_a[0], 1'b0);
    check("x0_any_a", any_busy_a, 1'b0);
    check("x0_data_b", rd_data_b[DW-1:0], 32'hFFFF_FFFF);
    check("x0_busy_b", rd_busy_b[0], 1'b1);
    advance();

    // reserve / release of x3
    set_idle(); flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd3; set_rd(3, 1, 2);
    check_point(); advance();
    set_idle(); rsv_en = 1'b1; rsv_addr = 5'd3;
    check_point(); advance();
    set_idle();
    check_point();
    check("rsv_x3_busy", rd_busy_a[0], 1'b1);
    advance();
    rsv_en = 1'b1; rsv_addr = 5'd3; set_wr(1, 3, 32'h0000_0033);
    check_point(); advance();
    set_idle();
    check_point();
    check("rsv_rel_x3_busy", rd_busy_a[0], 1'b1);
    advance();
    set_wr(1, 3, 32'h0000_0044);
    check_point(); advance();
    set_idle();
    check_point();
    check("rel_x3_busy", rd_busy_a[0], 1'b0);
    check("rel_x3_data", rd_data_a[DW-1:0], 32'h0000_0044);
    advance();

    // flush overrides a simultaneous reservation
    rsv_en = 1'b1; rsv_addr = 5'd9; set_rd(9, 10, 11);
    check_point(); advance();
    rsv_addr = 5'd10;
    check_point(); advance();
    set_idle();
    check_point();
    check("pre_flush_any", any_busy_a, 1'b1);
    advance();
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd11;
    check_point(); advance();
    set_idle();
    check_point();
    check("flush_any", any_busy_a, 1'b0);
    check("flush_x11_busy", rd_busy_a[2], 1'b0);
    advance();

    // randomized traffic with occasional reset
    for (int n = 0; n < 800; n++) begin
      set_idle();
      for (int w = 0; w < NW; w++) begin
        if ($urandom_range(0, 2) != 0)
          set_wr(w, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7), $urandom);
      end
      rsv_en   = $urandom_range(0, 1);
      rsv_addr = AW'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 15) == 0);
      set_rd($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31));
      if ($urandom_range(0, 49) == 0) begin
        wr_enable = '0;
        rst = 1'b0;
        model_reset();
        check_point();
        @(posedge clk);
        #1;
        rst = 1'b1;
      end else begin
        check_point();
        advance();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
